roberto_rx_serial: RTL and testbench
====================================

ROBERTO_RX_SERIAL -- requirements
Module: roberto_rx_serial

Interface
REQ-001 SHALL have parameter CICLOS_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud); minimum 4.
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port entrada_serial  input  1  asynchronous serial line, idle high, format 7O1 (start bit, 7 data bits LSB first, odd parity, 1 stop bit).
REQ-005 SHALL have port recebe_dado  input  1  consumer acknowledge; clears tem_dado.
REQ-006 SHALL have port dado_recebido  output  7  last received data bits.
REQ-007 SHALL have port pronto  output  1  one-cycle pulse when a frame completes.
REQ-008 SHALL have port tem_dado  output  1  unread data held in dado_recebido.
REQ-009 SHALL have port erro_paridade  output  1  parity error of the last frame.
REQ-010 SHALL have port erro_stop  output  1  stop bit of the last frame sampled low.
REQ-011 SHALL have port erro_overrun  output  1  sticky; a frame completed while tem_dado was 1.
REQ-012 SHALL have port db_estado  output  4  current FSM state code, for debug.

Function
REQ-013 SHALL pass entrada_serial through a 2-flip-flop synchronizer (reset value 1); all logic uses the synchronized value.
REQ-014 SHALL implement FSM states: inicial(0), espera(1), start(2), dados(3), paridade(4), stop(5), armazena(6), repouso(7).
REQ-015 inicial -> espera unconditionally after reset release; espera holds while the synchronized line is 1.
REQ-016 espera -> start on a synchronized 0; start waits CICLOS_BIT/2 cycles, then samples the line.
REQ-017 In start, a sampled 1 SHALL count as a false start: return to espera with no outputs changed.
REQ-018 In start, a sampled 0 -> dados; dados samples every CICLOS_BIT cycles, 7 samples, shifting LSB first.
REQ-019 paridade SHALL sample one bit after CICLOS_BIT cycles; the error is the XNOR-reduction of the 7 data bits and the parity bit (odd parity: error when total ones is even).
REQ-020 stop SHALL sample one bit after CICLOS_BIT cycles, then move to armazena.
REQ-021 armazena (one cycle) SHALL load dado_recebido, update erro_paridade and erro_stop, pulse pronto, and set tem_dado; data SHALL be stored even on error.
REQ-022 From armazena: stop sample 1 -> espera; stop sample 0 -> repouso; repouso -> espera once the synchronized line is 1.
REQ-023 erro_overrun SHALL set in armazena if tem_dado was already 1 and recebe_dado is not asserted in that cycle; it clears on recebe_dado.
REQ-024 recebe_dado SHALL clear tem_dado on the next edge, except in armazena, where the new frame wins and tem_dado stays 1.
REQ-025 The bit counter SHALL be 3 bits and the cycle counter ceil(log2(CICLOS_BIT)) bits; both restart on every state entry.
REQ-026 Latency from the start-bit falling edge to pronto SHALL be 2 + CICLOS_BIT/2 + 9*CICLOS_BIT + 1 cycles, within ±1.

Reset
REQ-027 On reset low: state inicial, dado_recebido=0, pronto=0, tem_dado=0, all error flags 0, counters 0, synchronizer 1; a frame in progress SHALL be discarded.

Structure
REQ-028 State encodings and the 7O1 frame constants (data width 7, parity odd) SHALL live in the shared package roberto_pkg, reused by the serial TX.
REQ-029 The cycle counter SHALL be a sub-module contador_m (modulus parameter, zera/conta inputs, fim output); the FSM and shift register stay in roberto_rx_serial.

Verification (CICLOS_BIT=8)
REQ-030 Send 0x41 with parity 1 and stop 1 -> pronto once, dado_recebido=0x41, tem_dado=1, erro_paridade=0, erro_stop=0.
REQ-031 Send 0x41 with parity 0 -> dado_recebido=0x41, erro_paridade=1.
REQ-032 Drive the line low for 3 cycles then high -> no pronto; db_estado returns to 1.
REQ-033 Send 0x55 with stop bit 0 and hold the line low 40 cycles -> erro_stop=1, db_estado=7 until the line goes high, then 1.
REQ-034 Send two frames with no recebe_dado -> erro_overrun=1 and dado_recebido holds the second byte; pulse recebe_dado -> tem_dado=0 and erro_overrun=0.
REQ-035 Assert reset mid-dados, release it, then send 0x2A -> no stale pronto, and 0x2A is received correctly.

Source files
------------

// File: rtl/roberto_pkg.sv
// rtl/roberto_pkg.sv - shared 7O1 serial frame constants and FSM state codes
//
// Shared by the serial RX and TX:
//   estado_t          : FSM state encodings (also exported as db_estado)
//   DATA_BITS         : data bits per frame (7)
//   PARIDADE_IMPAR    : 1 selects odd parity
//   erro_paridade_7o1 : 1 when data plus parity bit do not match the configured parity
package roberto_pkg;

  localparam int DATA_BITS = 7;
  localparam logic PARIDADE_IMPAR = 1'b1;

  typedef enum logic [3:0] {
    st_inicial  = 4'd0,
    st_espera   = 4'd1,
    st_start    = 4'd2,
    st_dados    = 4'd3,
    st_paridade = 4'd4,
    st_stop     = 4'd5,
    st_armazena = 4'd6,
    st_repouso  = 4'd7
  } estado_t;

  // Odd parity: the XOR of data plus parity must be 1.
  // A mismatch against PARIDADE_IMPAR flags the error.
  function automatic logic erro_paridade_7o1(input logic [DATA_BITS-1:0] d, input logic p);
    return (^{d, p}) != PARIDADE_IMPAR;
  endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M cycle counter with clear, enable and terminal flag
//
// Ports:
//   clock, reset : system clock, asynchronous active-low reset
//   zera         : synchronous clear (has priority over conta)
//   conta        : count enable; wraps from M-1 to 0
//   q            : current count
//   fim          : high while q == M-1
module contador_m #(
  parameter int M = 434,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      if (q == W'(M - 1)) begin
        q <= '0;
      end else begin
        q <= q + W'(1);
      end
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/roberto_rx_serial.sv
// rtl/roberto_rx_serial.sv - 7O1 asynchronous serial receiver
//
// Ports:
//   clock, reset   : system clock, asynchronous active-low reset
//   entrada_serial : serial line, idle high (start, 7 data LSB first, odd parity, stop)
//   recebe_dado    : consumer acknowledge, clears tem_dado and erro_overrun
//   dado_recebido  : last received 7 data bits
//   pronto         : one-cycle pulse when a frame has been stored
//   tem_dado       : unread data present in dado_recebido
//   erro_paridade  : parity error of the last frame
//   erro_stop      : stop bit of the last frame sampled low
//   erro_overrun   : sticky, a frame completed while tem_dado was still set
//   db_estado      : current FSM state code
module roberto_rx_serial
  import roberto_pkg::*;
#(
  parameter int CICLOS_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 entrada_serial,
  input  logic                 recebe_dado,
  output logic [DATA_BITS-1:0] dado_recebido,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 erro_overrun,
  output logic [3:0]           db_estado
);

  localparam int CW   = $clog2(CICLOS_BIT);
  localparam int HALF = CICLOS_BIT / 2;

  estado_t estado, proximo;

  logic sync1, rx;
  logic [CW-1:0] ciclo;
  logic fim_bit, fim_meio;
  logic zera, conta;
  logic [2:0] bit_cnt;
  logic bit_inc;
  logic amostra_dado, amostra_par, amostra_stop;
  logic [DATA_BITS-1:0] desloca;
  logic bit_par, bit_stop;

  // Two-stage synchronizer; resets to the idle level so no false start after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      rx    <= sync1;
    end
  end

  contador_m #(.M(CICLOS_BIT), .W(CW)) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .q     (ciclo),
    .fim   (fim_bit)
  );

  // The start bit is sampled half a bit period in, which centres every later sample.
  assign fim_meio = (ciclo == CW'(HALF - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= st_inicial;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo      = estado;
    amostra_dado = 1'b0;
    amostra_par  = 1'b0;
    amostra_stop = 1'b0;
    bit_inc      = 1'b0;
    case (estado)
      st_inicial: proximo = st_espera;
      st_espera: begin
        if (!rx) proximo = st_start;
      end
      st_start: begin
        if (fim_meio) proximo = rx ? st_espera : st_dados;
      end
      st_dados: begin
        if (fim_bit) begin
          amostra_dado = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) proximo = st_paridade;
          else bit_inc = 1'b1;
        end
      end
      st_paridade: begin
        if (fim_bit) begin
          amostra_par = 1'b1;
          proximo     = st_stop;
        end
      end
      st_stop: begin
        if (fim_bit) begin
          amostra_stop = 1'b1;
          proximo      = st_armazena;
        end
      end
      st_armazena: proximo = bit_stop ? st_espera : st_repouso;
      st_repouso: begin
        if (rx) proximo = st_espera;
      end
      default: proximo = st_inicial;
    endcase
  end

  // Both counters restart whenever the state changes.
  assign zera  = (proximo != estado);
  assign conta = ~zera;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (zera) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      desloca  <= '0;
      bit_par  <= 1'b0;
      bit_stop <= 1'b0;
    end else begin
      if (amostra_dado) desloca <= {rx, desloca[DATA_BITS-1:1]};
      if (amostra_par)  bit_par  <= rx;
      if (amostra_stop) bit_stop <= rx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dado_recebido <= '0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
      tem_dado      <= 1'b0;
      erro_overrun  <= 1'b0;
      pronto        <= 1'b0;
    end else begin
      pronto <= (estado == st_armazena);
      if (estado == st_armazena) begin
        // Data is kept even when the frame carries an error.
        dado_recebido <= desloca;
        erro_paridade <= erro_paridade_7o1(desloca, bit_par);
        erro_stop     <= ~bit_stop;
        // A new frame beats a simultaneous acknowledge.
        tem_dado      <= 1'b1;
      end else if (recebe_dado) begin
        tem_dado <= 1'b0;
      end
      if (recebe_dado) begin
        erro_overrun <= 1'b0;
      end else if (estado == st_armazena && tem_dado) begin
        erro_overrun <= 1'b1;
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_roberto_rx_serial.sv
// tb/tb_roberto_rx_serial.sv - self-checking bench for roberto_rx_serial
module tb_roberto_rx_serial;

  localparam int C = 8;

  logic       clock;
  logic       reset;
  logic       entrada_serial;
  logic       recebe_dado;
  logic [6:0] dado_recebido;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_stop;
  logic       erro_overrun;
  logic [3:0] db_estado;

  int checks;
  int errors;
  int cyc;
  int pronto_cnt;
  int t_pronto;
  int t_start;

  roberto_rx_serial #(.CICLOS_BIT(C)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .recebe_dado    (recebe_dado),
    .dado_recebido  (dado_recebido),
    .pronto         (pronto),
    .tem_dado       (tem_dado),
    .erro_paridade  (erro_paridade),
    .erro_stop      (erro_stop),
    .erro_overrun   (erro_overrun),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (pronto) begin
      pronto_cnt++;
      t_pronto = cyc;
    end
  end

  typedef struct {
    logic [6:0] d;
    logic       p;
    logic       s;
    logic [6:0] exp_d;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    entrada_serial = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] d, input logic p, input logic s);
    t_start = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 7; i++) hold(d[i], C);
    hold(p, C);
    hold(s, C);
    entrada_serial = 1'b1;
  endtask

  task automatic ack();
    recebe_dado = 1'b1;
    @(posedge clock);
    #1;
    recebe_dado = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    pronto_cnt = 0;
    t_pronto = 0;
    t_start = 0;
    reset = 1'b0;
    entrada_serial = 1'b1;
    recebe_dado = 1'b0;

    vecs[0] = '{7'h41, 1'b1, 1'b1, 7'h41, 1'b0, 1'b0};
    vecs[1] = '{7'h41, 1'b0, 1'b1, 7'h41, 1'b1, 1'b0};
    vecs[2] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0};
    vecs[3] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0};
    vecs[4] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b0};
    vecs[5] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0};
    vecs[6] = '{7'h2A, 1'b0, 1'b1, 7'h2A, 1'b0, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_estado", 32'(db_estado), 32'd0);
    check("reset_dado", 32'(dado_recebido), 32'd0);
    check("reset_flags", 32'({pronto, tem_dado, erro_paridade, erro_stop, erro_overrun}), 32'd0);
    reset = 1'b1;
    hold(1'b1, 5);
    check("idle_estado", 32'(db_estado), 32'd1);

    for (int k = 0; k < 7; k++) begin
      ack();
      pronto_cnt = 0;
      send(vecs[k].d, vecs[k].p, vecs[k].s);
      hold(1'b1, 6);
      check($sformatf("v%0d_pronto_cnt", k), 32'(pronto_cnt), 32'd1);
      check($sformatf("v%0d_dado", k), 32'(dado_recebido), 32'(vecs[k].exp_d));
      check($sformatf("v%0d_erro_paridade", k), 32'(erro_paridade), 32'(vecs[k].exp_pe));
      check($sformatf("v%0d_erro_stop", k), 32'(erro_stop), 32'(vecs[k].exp_se));
      check($sformatf("v%0d_tem_dado", k), 32'(tem_dado), 32'd1);
      check($sformatf("v%0d_overrun", k), 32'(erro_overrun), 32'd0);
      check($sformatf("v%0d_latency_ok", k),
            32'((t_pronto - t_start >= 78) && (t_pronto - t_start <= 80)), 32'd1);
    end

    ack();
    check("ack_tem_dado", 32'(tem_dado), 32'd0);

    pronto_cnt = 0;
    hold(1'b0, 3);
    hold(1'b1, 30);
    check("false_start_pronto", 32'(pronto_cnt), 32'd0);
    check("false_start_estado", 32'(db_estado), 32'd1);
    check("false_start_tem_dado", 32'(tem_dado), 32'd0);

    pronto_cnt = 0;
    send(7'h55, 1'b1, 1'b0);
    hold(1'b0, 32);
    check("stop0_pronto", 32'(pronto_cnt), 32'd1);
    check("stop0_erro_stop", 32'(erro_stop), 32'd1);
    check("stop0_dado", 32'(dado_recebido), 32'h55);
    check("stop0_erro_paridade", 32'(erro_paridade), 32'd0);
    check("stop0_repouso", 32'(db_estado), 32'd7);
    hold(1'b1, 5);
    check("stop0_back_espera", 32'(db_estado), 32'd1);

    ack();
    pronto_cnt = 0;
    send(7'h11, 1'b1, 1'b1);
    hold(1'b1, 4);
    check("ovr_first_flag", 32'(erro_overrun), 32'd0);
    send(7'h22, 1'b1, 1'b1);
    hold(1'b1, 4);
    check("ovr_pronto_cnt", 32'(pronto_cnt), 32'd2);
    check("ovr_flag", 32'(erro_overrun), 32'd1);
    check("ovr_dado", 32'(dado_recebido), 32'h22);
    check("ovr_tem_dado", 32'(tem_dado), 32'd1);
    hold(1'b1, 3);
    check("ovr_sticky", 32'(erro_overrun), 32'd1);
    ack();
    check("ovr_ack_tem_dado", 32'(tem_dado), 32'd0);
    check("ovr_ack_flag", 32'(erro_overrun), 32'd0);

    pronto_cnt = 0;
    hold(1'b0, C);
    hold(1'b1, C);
    hold(1'b0, 5);
    check("mid_dados_estado", 32'(db_estado), 32'd3);
    reset = 1'b0;
    entrada_serial = 1'b1;
    #1;
    check("mid_reset_estado", 32'(db_estado), 32'd0);
    check("mid_reset_dado", 32'(dado_recebido), 32'd0);
    check("mid_reset_flags", 32'({pronto, tem_dado, erro_paridade, erro_stop, erro_overrun}), 32'd0);
    hold(1'b1, 3);
    reset = 1'b1;
    hold(1'b1, 30);
    check("post_reset_no_pronto", 32'(pronto_cnt), 32'd0);
    check("post_reset_estado", 32'(db_estado), 32'd1);
    send(7'h2A, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("post_reset_pronto", 32'(pronto_cnt), 32'd1);
    check("post_reset_dado", 32'(dado_recebido), 32'h2A);
    check("post_reset_erro_paridade", 32'(erro_paridade), 32'd0);
    check("post_reset_erro_stop", 32'(erro_stop), 32'd0);
    check("post_reset_tem_dado", 32'(tem_dado), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
